calendar_set_ctrl: RTL
======================

Name: calendar_set_ctrl

Overview:
- Sequences the calendar's time-set mode. Converts three button levels (mode, up, down) into a set-mode flag, a one-hot field select, single-cycle inc/dec strobes with auto-repeat, and a display blink.
- The set flag feeds every field counter so that no carry ripples while the user edits.
- Sits between the debounced button inputs and the sec/min/hour/day/month/year counter chain.

Parameters:
- HOLD_CYC, 25000000, number of cycles up/down must be held before auto-repeat starts.
- RPT_CYC, 5000000, cycles between auto-repeat strobes once repeating.
- TIMEOUT_CYC, 500000000, idle cycles in set mode before the block returns to RUN.
- BLINK_CYC, 12500000, half-period of the blink output.
- CNT_BITS, $clog2(TIMEOUT_CYC), width of the shared internal cycle counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode_btn  in  1  debounced level, synchronous to clock
- up_btn  in  1  debounced level
- down_btn  in  1  debounced level
- set  out  1  1 while in set mode; drives the counter set inputs (suppresses carry)
- field_sel  out  6  one-hot field select: bit0 SEC, 1 MIN, 2 HOUR, 3 DAY, 4 MON, 5 YEAR; all zeros in RUN
- inc  out  1  one-cycle increment strobe for the selected field
- dec  out  1  one-cycle decrement strobe for the selected field
- blink  out  1  square wave in set mode, 0 in RUN

Behaviour:
- One clock. Reset is synchronous and active-high. The clock port is named clock and the reset port is named reset.
- All outputs are registered. Reset values: set=0, field_sel=0, inc=0, dec=0, blink=0. The state is RUN, all internal counters are 0, and the previous-sample registers are 0.
- Edge detect: a press is a button sampled high at edge k after being sampled low at edge k-1. The response is visible after edge k, a latency of 1 cycle.
- States: RUN, EDIT. An internal field index runs 0..5.
  - RUN: a mode press moves the block to EDIT with field=0. In the same cycle, set=1 and field_sel=000001. Up and down are ignored in RUN.
  - EDIT: a mode press advances the field index by one. A mode press on field 5 (YEAR) moves the block to RUN: set=0, field_sel=0.
  - EDIT: an up press gives inc=1 for one cycle; a down press gives dec=1 for one cycle.
- Priority on simultaneous presses:
  - Mode beats up/down: no inc/dec is issued that cycle and the repeat counter is cleared.
  - Up and down both high (press or hold): neither strobe is issued and the repeat counter is held at 0.
- Auto-repeat:
  - The repeat counter counts every cycle that exactly one of up/down is held in EDIT.
  - When the count reaches HOLD_CYC-1, a strobe is issued and the counter reloads to HOLD_CYC-RPT_CYC.
  - Subsequent strobes therefore come every RPT_CYC cycles.
  - Releasing the button clears the counter.
- Timeout:
  - The idle counter clears on any press or while any button is held in EDIT. Otherwise it increments.
  - At TIMEOUT_CYC-1 the block moves to RUN the next cycle and the field index is reset to 0.
  - The idle counter does not run in RUN.
- Blink:
  - On entry to EDIT, blink=1 and the blink counter is cleared.
  - blink toggles every BLINK_CYC cycles.
  - On entry to RUN, blink is forced to 0.
  - The blink counter clears on every field change, so the new field starts visibly on.
- Counter width: no counter may overflow. Each counter saturates or reloads as specified and never wraps through 0 unexpectedly.
- Reset mid-EDIT: the block returns to RUN within one cycle. Any inc/dec in flight is dropped.
- inc and dec are never both 1. Strobes are only issued while set=1.

Decomposition:
- A shared package (calendar_pkg) holds the field index constants (FLD_SEC..FLD_YEAR, NUM_FIELDS=6) and the state encoding localparams RUN/EDIT.
- One natural sub-module, btn_repeat: edge detect plus hold/repeat counter for a single button, instantiated twice (up, down). Its outputs are press_strobe and repeat_strobe.
- The FSM, timeout and blink stay in the top level.

Test Plan (HOLD_CYC=8, RPT_CYC=4, TIMEOUT_CYC=50, BLINK_CYC=5):
- Mode press cycling: reset, then 7 mode presses, each 1 cycle high and 3 cycles low.
  - Expect field_sel = 000001, 000010, 000100, 001000, 010000, 100000, then 0.
  - Expect set = 1 through the 6th press and 0 after the 7th.
  - Expect the next press to re-enter with 000001.
- Auto-repeat: in EDIT field 0, hold up for 20 cycles.
  - Expect an inc strobe 1 cycle after the press, then at held-cycle 8, then at cycles 12, 16 and 20.
  - Expect dec to stay 0 throughout.
- Conflicts:
  - Up and down rise on the same edge: expect no strobe for 20 cycles.
  - Mode and up rise together: expect the field to advance and inc=0.
- Timeout: enter EDIT and stay idle.
  - Expect set to drop to 0 exactly 50 cycles after the last button activity.
  - Expect blink=0 and field_sel=0.
  - Expect a held button to keep EDIT alive past 50 cycles.
- Blink: in EDIT, expect blink to read 1 for 5 cycles, then 0 for 5 cycles, repeating. A field advance forces blink=1 on the next cycle.
- Synchronous reset in EDIT while holding up: expect all outputs to be 0 on the cycle after the reset edge. The first mode press after reset is released enters field 0.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared field indices, FSM state encoding and the field one-hot decode for the
// calendar time-set controller.
package calendar_pkg;

    localparam int NUM_FIELDS = 6;

    typedef logic [2:0] fld_t;

    localparam fld_t FLD_SEC  = 3'd0;
    localparam fld_t FLD_MIN  = 3'd1;
    localparam fld_t FLD_HOUR = 3'd2;
    localparam fld_t FLD_DAY  = 3'd3;
    localparam fld_t FLD_MON  = 3'd4;
    localparam fld_t FLD_YEAR = 3'd5;

    typedef enum logic {
        RUN  = 1'b0,
        EDIT = 1'b1
    } state_e;

    function automatic logic [NUM_FIELDS-1:0] fld_onehot(input fld_t fld);
        return NUM_FIELDS'(1) << fld;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat timer for one debounced button level.
module btn_repeat #(
    parameter int HOLD_CYC = 25000000,
    parameter int RPT_CYC  = 5000000,
    parameter int CNT_BITS = 29
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    input  logic count_en,
    output logic press_strobe,
    output logic repeat_strobe
);

    logic                prev_q;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    assign press_strobe = btn & ~prev_q;

    // The counter only runs while this button is held and the owner allows it;
    // any other cycle drops it back to 0, which covers release and conflicts.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d         = '0;
        repeat_strobe = 1'b0;
        if (btn && count_en) begin
            if (cnt_q == CNT_BITS'(HOLD_CYC - 1)) begin
                repeat_strobe = 1'b1;
                cnt_d         = CNT_BITS'(HOLD_CYC - RPT_CYC);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= btn;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/calendar_set_ctrl.sv
// Time-set mode sequencer: mode/up/down levels to set flag, one-hot field select,
// inc/dec strobes with auto-repeat, idle timeout and display blink.
module calendar_set_ctrl
    import calendar_pkg::*;
#(
    parameter int HOLD_CYC    = 25000000,
    parameter int RPT_CYC     = 5000000,
    parameter int TIMEOUT_CYC = 500000000,
    parameter int BLINK_CYC   = 12500000,
    parameter int CNT_BITS    = $clog2(TIMEOUT_CYC)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mode_btn,
    input  logic                  up_btn,
    input  logic                  down_btn,
    output logic                  set,
    output logic [NUM_FIELDS-1:0] field_sel,
    output logic                  inc,
    output logic                  dec,
    output logic                  blink
);

    state_e                state_q, state_d;
    fld_t                  field_q, field_d;
    logic [CNT_BITS-1:0]   idle_q, idle_d;
    logic [CNT_BITS-1:0]   bcnt_q, bcnt_d;
    logic                  blink_q, blink_d;
    logic                  set_q, inc_q, inc_d, dec_q, dec_d;
    logic [NUM_FIELDS-1:0] field_sel_q;
    logic                  mode_prev_q;

    logic mode_press, up_press, up_rpt, down_press, down_rpt, rpt_en;

    assign mode_press = mode_btn & ~mode_prev_q;
    assign rpt_en     = (state_q == EDIT) & ~mode_press & (up_btn ^ down_btn);

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .CNT_BITS(CNT_BITS)) u_up (
        .clock         (clock),
        .reset         (reset),
        .btn           (up_btn),
        .count_en      (rpt_en),
        .press_strobe  (up_press),
        .repeat_strobe (up_rpt)
    );

    btn_repeat #(.HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC), .CNT_BITS(CNT_BITS)) u_down (
        .clock         (clock),
        .reset         (reset),
        .btn           (down_btn),
        .count_en      (rpt_en),
        .press_strobe  (down_press),
        .repeat_strobe (down_rpt)
    );

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        idle_d  = '0;
        bcnt_d  = '0;
        blink_d = 1'b0;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                field_d = FLD_SEC;
                if (mode_press) begin
                    state_d = EDIT;
                    blink_d = 1'b1;
                end
            end
            EDIT: begin
                if (mode_press) begin
                    // Field change restarts blink in the on phase.
                    if (field_q == FLD_YEAR) begin
                        state_d = RUN;
                        field_d = FLD_SEC;
                    end else begin
                        field_d = field_q + 3'd1;
                        blink_d = 1'b1;
                    end
                end else begin
                    if (!(up_btn && down_btn)) begin
                        inc_d = up_press | up_rpt;
                        dec_d = down_press | down_rpt;
                    end
                    if (bcnt_q == CNT_BITS'(BLINK_CYC - 1)) begin
                        blink_d = ~blink_q;
                    end else begin
                        blink_d = blink_q;
                        bcnt_d  = bcnt_q + 1'b1;
                    end
                    if (!(mode_btn || up_btn || down_btn)) begin
                        if (idle_q == CNT_BITS'(TIMEOUT_CYC - 1)) begin
                            state_d = RUN;
                            field_d = FLD_SEC;
                            blink_d = 1'b0;
                            bcnt_d  = '0;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            field_q     <= FLD_SEC;
            idle_q      <= '0;
            bcnt_q      <= '0;
            blink_q     <= 1'b0;
            set_q       <= 1'b0;
            field_sel_q <= '0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            idle_q      <= idle_d;
            bcnt_q      <= bcnt_d;
            blink_q     <= blink_d;
            set_q       <= (state_d == EDIT);
            field_sel_q <= (state_d == EDIT) ? fld_onehot(field_d) : '0;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            mode_prev_q <= mode_btn;
        end
    end

    assign set       = set_q;
    assign field_sel = field_sel_q;
    assign inc       = inc_q;
    assign dec       = dec_q;
    assign blink     = blink_q;

endmodule
